bpsk_modulator: RTL and testbench
=================================

# bpsk_modulator

Binary phase-shift-keying modulator for the transmit path of the BPSK modem. It takes a serial bit stream synchronous to the 200 MHz system clock and emits a signed 16-bit fixed-point carrier sample every clock. The carrier is a 32-sample-per-period sine at 6.25 MHz, and its phase is 0° or 180° according to the current input bit. Its output feeds the DAC/interpolation stage.

## Interface
Parameters:
- `LUT_DEPTH`, default 32: sine samples per carrier period; must be a power of two.
- `AMP`, default 16384: peak amplitude in LSBs (1.0 in Q2.14).

Ports:
- `clk`  input  1  system clock, 200 MHz.
- `rst`  input  1  asynchronous, active-low reset.
- `en`  input  1  clock enable for phase advance and output update.
- `in`  input  1  data bit, synchronous to `clk`. `0` selects 0° phase; `1` selects 180°.
- `out`  output  `FIXDT_16_WIDTH` (16)  signed two's-complement carrier sample in Q2.14; registered.

## Operation
- Phase accumulator `phase` is 5 bits wide (log2 `LUT_DEPTH`). It increments by 1 on each enabled edge and wraps from 31 to 0.
- Sine table: `LUT[k] = round(AMP·sin(2πk/32))`.
  - k = 0..8: 0, 3196, 6270, 9102, 11585, 13623, 15137, 16069, 16384.
  - k = 9..15: mirror of k = 7..1.
  - k = 16..31: negation of k = 0..15.
- On each rising edge with `en`=1:
  - `out <= (in ? -LUT[phase] : LUT[phase])`
  - `phase <= phase + 1`
- Negation is two's complement. The peak value ±16384 never overflows 16 bits, so no saturation logic is needed.
- `en`=0: `phase` and `out` hold their values.
- The phase is not aligned to symbols. A change on `in` takes effect on the next enabled edge regardless of `phase`, so the output shows an instantaneous 180° flip (sign inversion) mid-period.
- No framing or symbol-rate logic. Bit duration is set entirely upstream.

## Timing
- Reset (`rst`=0, asynchronous): `phase`=0 and `out`=0, held while `rst` is low.
- After reset release with `en`=1 and `in`=0, successive edges give `out` = 0, 3196, 6270, 9102, …
- Latency from a change on `in` to `out` is 1 cycle. The edge after `in` changes produces the inverted sample for the current phase.
- Carrier period: 32 enabled cycles.
- Simultaneous `en`=1 and `in` toggle: the new bit applies to the current `phase`, and `phase` still advances.
- Reset asserted mid-period clears state immediately. The next enabled edge after release outputs `LUT[0]`=0.

## Structure
- Shared package holds:
  - `FIXDT_16_WIDTH` = 16 and the Q2.14 fraction width (14).
  - `LUT_DEPTH` and the phase width.
- Sub-module `bpsk_sine_lut`: combinational 32-entry ROM, 5-bit address in, signed 16-bit sample out.
- The top level contains:
  - the phase counter,
  - the sign-select/negate logic,
  - the output register.

## Test plan
- Reset with `rst`=0 for 3 cycles: `out`=0 throughout. After release with `en`=1 and `in`=0, the first 9 samples are 0, 3196, 6270, 9102, 11585, 13623, 15137, 16069, 16384.
- `in`=0 for 32 cycles: samples 16..24 are 0, -3196, …, -16384. Sample 32 wraps back to 0.
- `in` toggles every 20 cycles for 10 toggles (the 100 ns pattern): each sample after a toggle equals the negation of the sample that `in`=0/1 alone would give at that phase, and the carrier phase continues uninterrupted.
- Hold `en`=0 for 5 cycles at phase 5: `out` stays at 13623. On resume the next sample is 15137.
- Assert `rst` at phase 12 with `in`=1: `out` goes to 0 asynchronously, and after release the sequence restarts at 0, -3196, …
- Check all 32 phases with `in`=1: `out` is exactly `-LUT[k]`, and the extremes are exactly ±16384 with no wrap.

Source files
------------

// File: rtl/bpsk_modulator_pkg.sv
// Shared constants and types for the BPSK modulator: Q2.14 sample format,
// carrier table depth and the quarter-wave sine reference.
package bpsk_modulator_pkg;

   localparam int unsigned FIXDT_16_WIDTH = 16;
   localparam int unsigned FIXDT_16_FRAC  = 14;
   localparam int unsigned LUT_DEPTH      = 32;
   localparam int unsigned PHASE_WIDTH    = $clog2(LUT_DEPTH);
   localparam int unsigned LUT_QUARTER    = LUT_DEPTH / 4;

   typedef logic signed [FIXDT_16_WIDTH-1:0] sample_t;
   typedef logic [PHASE_WIDTH-1:0]           phase_t;

   // First quarter-wave of round(16384*sin(2*pi*k/32)), rescaled to the requested peak.
   function automatic sample_t quarter_sine(input int unsigned k, input int amp);
      int base;
      int scaled;
      case (k)
         0:       base = 0;
         1:       base = 3196;
         2:       base = 6270;
         3:       base = 9102;
         4:       base = 11585;
         5:       base = 13623;
         6:       base = 15137;
         7:       base = 16069;
         8:       base = 16384;
         default: base = 0;
      endcase
      scaled = (base * amp + (1 << (FIXDT_16_FRAC - 1))) >>> FIXDT_16_FRAC;
      return sample_t'(scaled);
   endfunction

endpackage

// File: rtl/bpsk_sine_lut.sv
// Combinational 32-entry sine ROM built from a quarter-wave table by
// mirroring about k=8 and negating the second half-period.
module bpsk_sine_lut
   import bpsk_modulator_pkg::*;
#(
   parameter int AMP = 16384
) (
   input  logic [PHASE_WIDTH-1:0]           addr_i,
   output logic signed [FIXDT_16_WIDTH-1:0] sample_o
);

   localparam logic [PHASE_WIDTH-2:0] QUARTER_IDX = (PHASE_WIDTH-1)'(LUT_QUARTER);

   sample_t                qtab [LUT_QUARTER+1];
   logic [PHASE_WIDTH-2:0] half_idx;
   logic [PHASE_WIDTH-2:0] fold_idx;
   sample_t                mag;

   for (genvar g = 0; g <= int'(LUT_QUARTER); g++) begin : g_qtab
      assign qtab[g] = quarter_sine(g, AMP);
   end

   // 16 - idx wraps to -idx in the half-period index width.
   always_comb begin
      half_idx = addr_i[PHASE_WIDTH-2:0];
      fold_idx = half_idx;
      if (half_idx > QUARTER_IDX) begin
         fold_idx = (~half_idx) + 1'b1;
      end
      mag      = qtab[fold_idx];
      sample_o = addr_i[PHASE_WIDTH-1] ? -mag : mag;
   end

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK modulator: free-running carrier phase counter, sine lookup and
// per-sample sign flip selected by the incoming data bit.
module bpsk_modulator #(
   parameter int unsigned LUT_DEPTH = bpsk_modulator_pkg::LUT_DEPTH,
   parameter int          AMP       = 16384
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                en,
   input  logic                                                in,
   output logic signed [bpsk_modulator_pkg::FIXDT_16_WIDTH-1:0] out
);

   import bpsk_modulator_pkg::sample_t;
   import bpsk_modulator_pkg::PHASE_WIDTH;

   localparam int unsigned PW = $clog2(LUT_DEPTH);

   logic [PW-1:0] phase_q, phase_d;
   sample_t       out_q, out_d;
   sample_t       lut_sample;

   // Deeper accumulators index the fixed-resolution table by their MSBs.
   bpsk_sine_lut #(
      .AMP (AMP)
   ) u_lut (
      .addr_i   (phase_q[PW-1 -: PHASE_WIDTH]),
      .sample_o (lut_sample)
   );

   always_comb begin
      phase_d = phase_q;
      out_d   = out_q;
      if (en) begin
         phase_d = phase_q + 1'b1;
         out_d   = in ? -lut_sample : lut_sample;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= '0;
         out_q   <= '0;
      end else begin
         phase_q <= phase_d;
         out_q   <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_bpsk_modulator.sv
// Self-checking bench for bpsk_modulator against a table-driven carrier model.
`timescale 1ns/1ps
module tb_bpsk_modulator;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en  = 1'b0;
   logic               in  = 1'b0;
   logic signed [15:0] out;

   int checks   = 0;
   int failures = 0;
   int lut [32];
   int m_phase  = 0;
   int m_out    = 0;

   always #2.5 clk = ~clk;

   bpsk_modulator #(
      .LUT_DEPTH (32),
      .AMP       (16384)
   ) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .in  (in),
      .out (out)
   );

   function automatic void build_lut();
      int q [9];
      q = '{0, 3196, 6270, 9102, 11585, 13623, 15137, 16069, 16384};
      for (int k = 0; k <= 8; k++)  lut[k] = q[k];
      for (int k = 9; k <= 15; k++) lut[k] = q[16 - k];
      for (int k = 16; k < 32; k++) lut[k] = -lut[k - 16];
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_out   = 0;
   endtask

   // Drive inputs just after an edge, take the next edge, then update the model.
   task automatic clock_step(input logic en_v, input logic in_v);
      en = en_v;
      in = in_v;
      @(posedge clk);
      #1;
      if (rst && en_v) begin
         m_out   = in_v ? -lut[m_phase] : lut[m_phase];
         m_phase = (m_phase + 1) % 32;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      int first9 [9];
      first9 = '{0, 3196, 6270, 9102, 11585, 13623, 15137, 16069, 16384};
      en  = 1'b1;
      in  = 1'b0;
      clock_step(1'b1, 1'b0);
      clock_step(1'b1, 1'b0);
      rst = 1'b0;
      #1;
      checks++;
      if (out !== 16'sd0) begin
         failures++;
         $display("FAIL reset_async out=%0d expected=0", out);
      end
      model_reset();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out !== 16'sd0) begin
            failures++;
            $display("FAIL reset_hold cycle=%0d out=%0d expected=0", c, out);
         end
      end
      rst = 1'b1;
      for (int s = 0; s < 9; s++) begin
         clock_step(1'b1, 1'b0);
         checks++;
         if (out !== 16'(first9[s])) begin
            failures++;
            $display("FAIL reset_first9 sample=%0d out=%0d expected=%0d", s, out, first9[s]);
         end
      end
   endtask

   task automatic test_ramp();
      do_reset();
      for (int s = 0; s <= 32; s++) begin
         clock_step(1'b1, 1'b0);
         checks++;
         if (out !== 16'(lut[s % 32])) begin
            failures++;
            $display("FAIL ramp sample=%0d out=%0d expected=%0d", s, out, lut[s % 32]);
         end
         if (s == 24) begin
            checks++;
            if (out !== -16'sd16384) begin
               failures++;
               $display("FAIL ramp_trough out=%0d expected=-16384", out);
            end
         end
      end
   endtask

   task automatic test_toggle();
      int   expv;
      logic bit_v;
      do_reset();
      for (int i = 0; i < 220; i++) begin
         bit_v = 1'((i / 20) % 2);
         clock_step(1'b1, bit_v);
         expv = bit_v ? -lut[i % 32] : lut[i % 32];
         checks++;
         if (out !== 16'(expv)) begin
            failures++;
            $display("FAIL toggle cycle=%0d in=%0b out=%0d expected=%0d", i, bit_v, out, expv);
         end
      end
   endtask

   task automatic test_enable_hold();
      do_reset();
      for (int s = 0; s < 6; s++) clock_step(1'b1, 1'b0);
      checks++;
      if (out !== 16'sd13623) begin
         failures++;
         $display("FAIL hold_pre out=%0d expected=13623", out);
      end
      for (int c = 0; c < 5; c++) begin
         clock_step(1'b0, 1'($urandom_range(0, 1)));
         checks++;
         if (out !== 16'sd13623) begin
            failures++;
            $display("FAIL hold_en0 cycle=%0d out=%0d expected=13623", c, out);
         end
      end
      clock_step(1'b1, 1'b0);
      checks++;
      if (out !== 16'sd15137) begin
         failures++;
         $display("FAIL hold_resume out=%0d expected=15137", out);
      end
   endtask

   task automatic test_mid_reset();
      int restart [4];
      restart = '{0, -3196, -6270, -9102};
      do_reset();
      for (int s = 0; s < 12; s++) clock_step(1'b1, 1'b1);
      checks++;
      if (out !== 16'(-lut[11])) begin
         failures++;
         $display("FAIL midrst_pre out=%0d expected=%0d", out, -lut[11]);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (out !== 16'sd0) begin
         failures++;
         $display("FAIL midrst_async out=%0d expected=0", out);
      end
      model_reset();
      @(posedge clk);
      #1;
      checks++;
      if (out !== 16'sd0) begin
         failures++;
         $display("FAIL midrst_hold out=%0d expected=0", out);
      end
      rst = 1'b1;
      for (int s = 0; s < 4; s++) begin
         clock_step(1'b1, 1'b1);
         checks++;
         if (out !== 16'(restart[s])) begin
            failures++;
            $display("FAIL midrst_restart sample=%0d out=%0d expected=%0d", s, out, restart[s]);
         end
      end
   endtask

   task automatic test_all_phases_inverted();
      do_reset();
      for (int k = 0; k < 32; k++) begin
         clock_step(1'b1, 1'b1);
         checks++;
         if (out !== 16'(-lut[k])) begin
            failures++;
            $display("FAIL inv_phase k=%0d out=%0d expected=%0d", k, out, -lut[k]);
         end
         if (k == 8 || k == 24) begin
            checks++;
            if (out !== ((k == 8) ? -16'sd16384 : 16'sd16384)) begin
               failures++;
               $display("FAIL inv_extreme k=%0d out=%0d expected=%0d", k, out, (k == 8) ? -16384 : 16384);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         clock_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
         checks++;
         if (out !== 16'(m_out)) begin
            failures++;
            $display("FAIL random cycle=%0d out=%0d expected=%0d", i, out, m_out);
         end
      end
   endtask

   initial begin
      build_lut();
      #1;
      test_reset();
      test_ramp();
      test_toggle();
      test_enable_hold();
      test_mid_reset();
      test_all_phases_inverted();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
